// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for the sequential ALU
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_Sel;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] ALU_Result;
  logic [7:0]  Quotient;
  logic [7:0]  Remainder;
  logic        CarryOut;
  logic        DivideByZero;
  logic        busy;
  modport master (
    output req_valid, A, B, ALU_Sel, resp_ready,
    input  req_ready, resp_valid, ALU_Result, Quotient, Remainder, CarryOut, DivideByZero, busy
  );
  modport slave (
    input  req_valid, A, B, ALU_Sel, resp_ready,
    output req_ready, resp_valid, ALU_Result, Quotient, Remainder, CarryOut, DivideByZero, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with single-cycle ops and 8-step shift-add multiply / restoring divide
module alu_seq_unit (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state;
  logic [7:0]  a_r, b_r, dvd, quo, rem;
  logic [3:0]  op;
  logic [2:0]  cnt;
  logic [15:0] prod;
  logic        req_ready, resp_valid, busy, carry, dz;
  logic [15:0] result;
  logic [7:0]  quotient, remainder;
  logic [8:0]  sum, trial;
  logic [15:0] sc_res, addend, prod_nx;
  logic [7:0]  rem_nx, quo_nx;
  logic        sc_c, ge, multi;
  // single-cycle results from the live inputs, plus one multiply/divide step from the latched operands
  always_comb begin
    sum     = {1'b0, bus.A} + {1'b0, bus.B};
    sc_res  = bus.ALU_Sel == 4'b0000 ? {7'b0, sum} :
              bus.ALU_Sel == 4'b0001 ? {8'b0, bus.A - bus.B} :
              bus.ALU_Sel == 4'b0100 ? {8'b0, bus.A[6:0], 1'b0} :
              bus.ALU_Sel == 4'b0101 ? {9'b0, bus.A[7:1]} :
              bus.ALU_Sel == 4'b1000 ? {8'b0, bus.A & bus.B} :
              bus.ALU_Sel == 4'b1001 ? {8'b0, bus.A | bus.B} :
              bus.ALU_Sel == 4'b1010 ? {8'b0, bus.A ^ bus.B} :
              bus.ALU_Sel == 4'b1110 ? {15'b0, bus.A > bus.B} :
              bus.ALU_Sel == 4'b1111 ? {15'b0, bus.A == bus.B} : 16'd0;
    sc_c    = bus.ALU_Sel == 4'b0000 ? sum[8] :
              bus.ALU_Sel == 4'b0001 ? bus.A < bus.B :
              bus.ALU_Sel == 4'b0100 ? bus.A[7] :
              bus.ALU_Sel == 4'b0101 ? bus.A[0] : 1'b0;
    multi   = bus.ALU_Sel == 4'b0010 || (bus.ALU_Sel == 4'b0011 && bus.B != 8'd0);
    addend  = b_r[cnt] ? {8'b0, a_r} << cnt : 16'd0;
    prod_nx = prod + addend;
    trial   = {rem, dvd[7]};
    ge      = trial >= {1'b0, b_r};
    rem_nx  = ge ? trial[7:0] - b_r : trial[7:0];
    quo_nx  = {quo[6:0], ge};
  end
  // control FSM with registered handshake, busy and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      result     <= 16'd0;
      quotient   <= 8'd0;
      remainder  <= 8'd0;
      carry      <= 1'b0;
      dz         <= 1'b0;
      cnt        <= 3'd0;
      a_r        <= 8'd0;
      b_r        <= 8'd0;
      op         <= 4'd0;
      dvd        <= 8'd0;
      quo        <= 8'd0;
      rem        <= 8'd0;
      prod       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            a_r       <= bus.A;
            b_r       <= bus.B;
            op        <= bus.ALU_Sel;
            dvd       <= bus.A;
            quo       <= 8'd0;
            rem       <= 8'd0;
            prod      <= 16'd0;
            cnt       <= 3'd0;
            req_ready <= 1'b0;
            if (multi) begin
              state <= EXEC;
              busy  <= 1'b1;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              result     <= sc_res;
              carry      <= sc_c;
              quotient   <= 8'd0;
              remainder  <= 8'd0;
              dz         <= bus.ALU_Sel == 4'b0011;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        EXEC: begin
          cnt  <= cnt + 3'd1;
          prod <= prod_nx;
          rem  <= rem_nx;
          quo  <= quo_nx;
          dvd  <= {dvd[6:0], 1'b0};
          if (cnt == 3'd7) begin
            state      <= RESP;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            carry      <= 1'b0;
            dz         <= 1'b0;
            result     <= op == 4'b0010 ? prod_nx : {8'b0, quo_nx};
            quotient   <= op == 4'b0010 ? 8'd0 : quo_nx;
            remainder  <= op == 4'b0010 ? 8'd0 : rem_nx;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready    = req_ready;
  assign bus.resp_valid   = resp_valid;
  assign bus.busy         = busy;
  assign bus.ALU_Result   = result;
  assign bus.Quotient     = quotient;
  assign bus.Remainder    = remainder;
  assign bus.CarryOut     = carry;
  assign bus.DivideByZero = dz;
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port req_valid  in  1  request present.
REQ-004 SHALL have port req_ready  out  1  unit can accept a request.
REQ-005 SHALL have ports A, B  in  8 each  operands, unsigned.
REQ-006 SHALL have port ALU_Sel  in  4  opcode.
REQ-007 SHALL have port resp_valid  out  1  response outputs are valid.
REQ-008 SHALL have port resp_ready  in  1  consumer takes the response.
REQ-009 SHALL have port ALU_Result  out  16  result.
REQ-010 SHALL have ports Quotient, Remainder  out  8 each  division outputs.
REQ-011 SHALL have ports CarryOut, DivideByZero  out  1 each  flags.
REQ-012 SHALL have port busy  out  1  high while a multi-cycle operation iterates.

Function
REQ-013 SHALL implement states IDLE, EXEC and RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-014 SHALL accept a request on a rising edge with req_valid&&req_ready, latching A, B and ALU_Sel; input changes after acceptance SHALL be ignored.
REQ-015 Single-cycle ops and divide-by-zero SHALL go IDLE->RESP, so resp_valid is high the cycle after the accept edge.
REQ-016 Multiply and divide with B!=0 SHALL go IDLE->EXEC, run 8 iterations with busy=1 (3-bit counter), then go to RESP, so resp_valid is high 9 cycles after the accept edge.
REQ-017 In RESP all outputs SHALL hold stable until resp_ready=1 on a rising edge; the unit then returns to IDLE, and the next accept occurs no earlier than the following edge.
REQ-018 After retirement, result and flag outputs SHALL hold their last values with resp_valid=0.
REQ-019 0000 add: ALU_Result={7'b0, A+B (9 bits)}, CarryOut=sum bit 8.
REQ-020 0001 sub: ALU_Result={8'b0, (A-B) mod 256}, CarryOut=1 iff A<B (borrow).
REQ-021 0010 mul: shift-add, ALU_Result=A*B (16 bits), CarryOut=0.
REQ-022 0011 div: restoring, one quotient bit per EXEC cycle; Quotient=A/B, Remainder=A%B, ALU_Result={8'b0, Quotient}.
REQ-023 0011 with B=0: DivideByZero=1, ALU_Result=0, Quotient=0, Remainder=0; for every other opcode DivideByZero=0.
REQ-024 0100 shl: ALU_Result={8'b0, A<<1}, CarryOut=A[7]; 0101 shr: ALU_Result={8'b0, A>>1}, CarryOut=A[0].
REQ-025 1000/1001/1010 SHALL give AND/OR/XOR zero-extended to 16 bits; 1110 SHALL give ALU_Result=1 iff A>B; 1111 SHALL give ALU_Result=1 iff A==B; CarryOut=0 for all of these.
REQ-026 Unlisted opcodes SHALL complete in 1 cycle with all result and flag outputs 0.
REQ-027 Quotient and Remainder SHALL be 0 for all non-divide opcodes.

Reset
REQ-028 While rst=1, independent of clk: state=IDLE, req_ready=0, resp_valid=0, busy=0, ALU_Result=0, Quotient=0, Remainder=0, CarryOut=0, DivideByZero=0, iteration counter=0.
REQ-029 rst asserted mid-EXEC or mid-RESP SHALL abort the operation with no response issued; req_ready=1 on the first cycle after rst deasserts.

Verification
REQ-030 add A=200, B=100 -> resp_valid 1 cycle after accept, ALU_Result=300 (0x012C), CarryOut=1.
REQ-031 mul A=255, B=255 -> busy high exactly 8 cycles, resp_valid 9 cycles after accept, ALU_Result=65025, CarryOut=0.
REQ-032 div A=255, B=16 -> Quotient=15, Remainder=15, ALU_Result=15 at 9-cycle latency; A=40, B=0 -> DivideByZero=1, Quotient=0, Remainder=0, 1-cycle latency.
REQ-033 sub A=10, B=30 -> ALU_Result=236, CarryOut=1; equal A=25, B=25 -> ALU_Result=1; greater A=20, B=50 -> ALU_Result=0.
REQ-034 Backpressure: hold resp_ready=0 for 5 cycles after an AND of 0xAA, 0xCC -> ALU_Result=0x0088 stable, req_ready=0 and a pending req_valid not accepted; after handshake the pending request is accepted on the following edge.
REQ-035 Assert rst in EXEC cycle 4 of div 40/5 -> all outputs 0 immediately, no resp_valid; after release, add 20+15 -> ALU_Result=35, CarryOut=0.
